// File: rtl/cnt_pkg.sv
// Shared constants for the sync-counter consumer blocks.
package cnt_pkg;
  localparam int CNT_W    = 4;
  localparam int DUTY_W   = CNT_W + 1;
  localparam int CNT_MAX  = 2**CNT_W - 1;
  localparam int DUTY_MAX = 2**CNT_W;
endpackage

// File: rtl/pwm_duty_shadow.sv
// Duty request/ack handshake with a pending shadow that is promoted to the
// active duty only on a period boundary.
module pwm_duty_shadow
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] duty_in,
  input  logic           duty_req,
  input  logic           apply,
  output logic [WIDTH:0] active,
  output logic           duty_ack
);
  localparam logic [WIDTH:0] DMAX = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH:0] pend;
  logic           pend_v;
  logic [WIDTH:0] duty_clamped;

  assign duty_clamped = (duty_in > DMAX) ? DMAX : duty_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_v   <= 1'b0;
      active   <= '0;
      duty_ack <= 1'b0;
    end else begin
      duty_ack <= duty_req;
      if (apply && pend_v) begin
        active <= pend;
        pend_v <= 1'b0;
      end
      // A request on the apply clk becomes the next pending value.
      if (duty_req) begin
        pend   <= duty_clamped;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/count_pwm_gen.sv
// Samples the free-running sync counter, flags broken count sequences, tallies
// period wraps and drives a registered PWM compare against the active duty.
module count_pwm_gen
  import cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_W,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   cnt,
  input  logic [WIDTH:0]     duty_in,
  input  logic               duty_req,
  output logic               duty_ack,
  output logic               pwm,
  output logic               wrap,
  output logic [TALLY_W-1:0] wraps,
  output logic               step_err
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_exp;
  logic             primed;
  logic             wrap_hit;
  logic [WIDTH:0]   active;

  assign cnt_exp  = cnt_q + WIDTH'(1);
  assign wrap_hit = primed && (cnt_q == '1) && (cnt == '0);

  pwm_duty_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .duty_in  (duty_in),
    .duty_req (duty_req),
    .apply    (wrap_hit),
    .active   (active),
    .duty_ack (duty_ack)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      primed   <= 1'b0;
      step_err <= 1'b0;
      wrap     <= 1'b0;
      wraps    <= '0;
      pwm      <= 1'b0;
    end else begin
      cnt_q  <= cnt;
      primed <= 1'b1;
      if (primed && (cnt != cnt_exp))
        step_err <= 1'b1;
      wrap <= wrap_hit;
      if (wrap_hit)
        wraps <= wraps + TALLY_W'(1);
      // Uses the pre-edge active duty, so cnt=0 of a new period still sees the old one.
      pwm <= ({1'b0, cnt} < active);
    end
  end
endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: a vector table plus free-running period sequences.
module tb_count_pwm_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt;
  logic [4:0] duty_in;
  logic       duty_req;
  logic       duty_ack, pwm, wrap, step_err;
  logic [7:0] wraps;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] cnt;
    logic       req;
    logic [4:0] duty;
    logic       pwm;
    logic       wrap;
    logic       ack;
    logic       err;
    logic [7:0] wraps;
  } vec_t;

  vec_t vq[$];

  count_pwm_gen #(.WIDTH(4), .TALLY_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .duty_in  (duty_in),
    .duty_req (duty_req),
    .duty_ack (duty_ack),
    .pwm      (pwm),
    .wrap     (wrap),
    .wraps    (wraps),
    .step_err (step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", name, k, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pwm"},   0, int'(pwm),      0);
    chk({tag, "_wrap"},  0, int'(wrap),     0);
    chk({tag, "_ack"},   0, int'(duty_ack), 0);
    chk({tag, "_err"},   0, int'(step_err), 0);
    chk({tag, "_wraps"}, 0, int'(wraps),    0);
  endtask

  task automatic reset_dut();
    rst = 1'b0; cnt = '0; duty_req = 1'b0; duty_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
  endtask

  task automatic add(input int c, input int rq, input int d, input int p, input int w,
                     input int a, input int e, input int ws);
    vec_t v;
    v.cnt = 4'(c); v.req = 1'(rq); v.duty = 5'(d); v.pwm = 1'(p);
    v.wrap = 1'(w); v.ack = 1'(a); v.err = 1'(e); v.wraps = 8'(ws);
    vq.push_back(v);
  endtask

  // Free-running counter from 0 after reset release; tick k samples cnt=(k-1)%16.
  // Requests are placed at ticks rk1/rk2, active duty av1 from tick ak1, av2 from ak2.
  task automatic run_seq(input string name, input int n, input int rk1, input int rd1,
                         input int rk2, input int rd2, input int ak1, input int av1,
                         input int ak2, input int av2);
    int act, nw;
    nw = 0;
    for (int k = 1; k <= n; k++) begin
      duty_req = (k == rk1) || (k == rk2);
      duty_in  = (k == rk1) ? 5'(rd1) : 5'(rd2);
      @(posedge clk);
      #1;
      duty_req = 1'b0;
      act = 0;
      if (ak1 > 0 && k >= ak1) act = av1;
      if (ak2 > 0 && k >= ak2) act = av2;
      if (k > 1 && ((k - 1) % 16) == 0) nw++;
      chk({name, "_pwm"},   k, int'(pwm),      int'(((k - 1) % 16) < act));
      chk({name, "_wrap"},  k, int'(wrap),     int'(k > 1 && ((k - 1) % 16) == 0));
      chk({name, "_ack"},   k, int'(duty_ack), int'(k == rk1 || k == rk2));
      chk({name, "_err"},   k, int'(step_err), 0);
      chk({name, "_wraps"}, k, int'(wraps),    nw);
      cnt = 4'(k % 16);
    end
  endtask

  initial begin
    // Bench-driven counter: prime at 9, clamp, apply, step errors, wrap after a skip.
    add(9, 0, 0,  0, 0, 0, 0, 0);
    add(10, 0, 0, 0, 0, 0, 0, 0);
    add(11, 1, 20, 0, 0, 1, 0, 0);
    add(12, 0, 0, 0, 0, 0, 0, 0);
    add(13, 0, 0, 0, 0, 0, 0, 0);
    add(14, 0, 0, 0, 0, 0, 0, 0);
    add(15, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0, 1);
    add(1, 0, 0,  1, 0, 0, 0, 1);
    add(2, 1, 3,  1, 0, 1, 0, 1);
    for (int c = 3; c <= 15; c++) add(c, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0,  1, 1, 0, 0, 2);
    add(1, 0, 0,  1, 0, 0, 0, 2);
    add(2, 0, 0,  1, 0, 0, 0, 2);
    add(3, 0, 0,  0, 0, 0, 0, 2);
    add(4, 0, 0,  0, 0, 0, 0, 2);
    add(5, 0, 0,  0, 0, 0, 0, 2);
    add(7, 0, 0,  0, 0, 0, 1, 2);
    add(7, 0, 0,  0, 0, 0, 1, 2);
    add(8, 0, 0,  0, 0, 0, 1, 2);
    add(15, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0,  1, 1, 0, 1, 3);
    add(2, 0, 0,  1, 0, 0, 1, 3);

    reset_dut();
    for (int i = 0; i < vq.size(); i++) begin
      cnt = vq[i].cnt; duty_req = vq[i].req; duty_in = vq[i].duty;
      @(posedge clk);
      #1;
      duty_req = 1'b0;
      chk("tbl_pwm",   i, int'(pwm),      int'(vq[i].pwm));
      chk("tbl_wrap",  i, int'(wrap),     int'(vq[i].wrap));
      chk("tbl_ack",   i, int'(duty_ack), int'(vq[i].ack));
      chk("tbl_err",   i, int'(step_err), int'(vq[i].err));
      chk("tbl_wraps", i, int'(wraps),    int'(vq[i].wraps));
    end

    reset_dut(); run_seq("idle",   40, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_dut(); run_seq("duty4",  48, 8, 4, 0, 0, 18, 4, 0, 0);
    reset_dut(); run_seq("latest", 48, 4, 4, 10, 12, 18, 12, 0, 0);
    reset_dut(); run_seq("onwrap", 49, 2, 2, 17, 8, 18, 2, 34, 8);
    reset_dut(); run_seq("full",   64, 3, 16, 20, 0, 18, 16, 34, 0);
    reset_dut(); run_seq("clamp",  48, 5, 31, 0, 0, 18, 16, 0, 0);

    // Mid-period async reset with a pending duty held; it must be discarded.
    reset_dut(); run_seq("prerst", 20, 3, 16, 19, 5, 18, 16, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    cnt = '0;
    rst = 1'b1;
    run_seq("postrst", 40, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
